bus_slave_responder: RTL and testbench



---
 rtl/bus_slave_responder_pkg.sv | 24 ++
 rtl/bus_slave_responder_addr_window_check.sv | 37 +++
 rtl/bus_slave_responder.sv | 126 ++++++++++++
 tb/tb_bus_slave_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_responder_pkg.sv
// Shared definitions for the request/acknowledge bus responder: FSM encodings,
// default bus widths and a constant-evaluable clog2 helper.
// Pure declarations; no logic, no latency, no flow control of its own.
package bus_slave_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bus_slave_responder_addr_window_check.sv
// Address window decode: flags addr in [BASE, BASE+DEPTH) and yields the word index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no handshake and only evaluates its input.
module addr_window_check #(
   parameter int                ADDR_W = 8,
   parameter logic [ADDR_W-1:0] BASE   = ADDR_W'('h40),
   parameter int                DEPTH  = 16,
   parameter int                IDX_W  = 4
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              in_range,
   output logic [IDX_W-1:0]  index
);

   // One bit wider than the address so BASE+DEPTH reaching 2^ADDR_W does not wrap.
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(DEPTH);

   // Unsigned a < b taken from the sign bit of an (ADDR_W+1)-bit difference;
   // both operands stay below 2^(ADDR_W+1)/2 + 1, so the sign bit is exact.
   function automatic logic ult(input logic [ADDR_W:0] a, input logic [ADDR_W:0] b);
      logic [ADDR_W:0] diff;
      diff = a - b;
      return diff[ADDR_W];
   endfunction

   logic below_base;
   logic below_limit;

   // Window test plus offset into the register file (low bits of addr-BASE).
   always_comb begin
      below_base  = ult({1'b0, addr}, {1'b0, BASE});
      below_limit = ult({1'b0, addr}, LIMIT);
      in_range    = !below_base && below_limit;
      index       = addr[IDX_W-1:0] - BASE[IDX_W-1:0];
   end

endmodule

// File: rtl/bus_slave_responder.sv
// Bus responder: decodes a fixed address window into a DEPTH-word register file.
// Latency: ack WAIT_CYC+1 cycles after req is sampled in range, 1 cycle out of range.
// Backpressure: 4-phase; a held req is never re-accepted until it drops. Optional
// macro SLAVE_ABORT_EN lets a req drop during the wait phase abort the access.
module bus_slave_responder
   import bus_slave_responder_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] BASE     = ADDR_W'('h40),
   parameter int                DEPTH    = 16,
   parameter int                WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err
);

   localparam int IDX_W    = clog2(DEPTH);
   localparam int CNT_W    = (WAIT_CYC > 0) ? clog2(WAIT_CYC + 1) : 1;
   localparam int CNT_INIT = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

   state_t             state, nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               cap;

   logic               win_in;
   logic [IDX_W-1:0]   win_idx;

   logic               h_wr;
   logic               h_err;
   logic [IDX_W-1:0]   h_idx;
   logic [DATA_W-1:0]  h_wdata;

   logic [DATA_W-1:0]  mem [DEPTH];

   addr_window_check #(
      .ADDR_W (ADDR_W),
      .BASE   (BASE),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_win (
      .addr     (addr),
      .in_range (win_in),
      .index    (win_idx)
   );

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; the window decision uses the live address only in IDLE.
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      cap     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               cap = 1'b1;
               if (!win_in || WAIT_CYC == 0) begin
                  nxt = ST_RESP;
               end else begin
                  nxt     = ST_WAIT;
                  cnt_nxt = CNT_W'(CNT_INIT);
               end
            end
         end
         ST_WAIT: begin
`ifdef SLAVE_ABORT_EN
            if (!req) nxt = ST_IDLE;
            else
`endif
            if (cnt == '0) nxt = ST_RESP;
            else           cnt_nxt = cnt - CNT_W'(1);
         end
         ST_RESP: nxt = ST_DONE;
         ST_DONE: if (!req) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   // Holding registers: the access is frozen at acceptance so later bus changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_wr    <= 1'b0;
         h_err   <= 1'b0;
         h_idx   <= '0;
         h_wdata <= '0;
      end else if (cap) begin
         h_wr    <= wr;
         h_err   <= !win_in;
         h_idx   <= win_idx;
         h_wdata <= wdata;
      end
   end

   // Registered response and register-file commit, both taken at the end of RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         ack   <= (state == ST_RESP);
         err   <= (state == ST_RESP) && h_err;
         rdata <= (state == ST_RESP && !h_err && !h_wr) ? mem[h_idx] : '0;
         if (state == ST_RESP && !h_err && h_wr) mem[h_idx] <= h_wdata;
      end
   end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder: one instance with the default window
// (0x40/16/2 wait states) and one at the top of the address space (0xF8/8/0).
// Honours SLAVE_ABORT_EN for the req-drop-during-wait scenario.
module tb_bus_slave_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata_a, rdata_b;
   logic       ack_a, ack_b, err_a, err_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_slave_responder #(
      .ADDR_W(8), .DATA_W(8), .BASE(8'h40), .DEPTH(16), .WAIT_CYC(2)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .err(err_a)
   );

   bus_slave_responder #(
      .ADDR_W(8), .DATA_W(8), .BASE(8'hF8), .DEPTH(8), .WAIT_CYC(0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .err(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "/ack"},   {31'd0, ack_a}, 32'd0);
      chk({tag, "/err"},   {31'd0, err_a}, 32'd0);
      chk({tag, "/rdata"}, {24'd0, rdata_a}, 32'd0);
   endtask

   // One full handshake on DUT a (sel=0) or b (sel=1); lat counts edges after the sampling edge.
   task automatic xact(input bit sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int lat, input logic e_err, input logic [7:0] e_rd, input string tag);
      int   k;
      logic got;
      @(negedge clk);
      wr = w; addr = a; wdata = d;
      if (sel) req_b = 1'b1; else req_a = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 12) begin
         @(posedge clk); #1;
         if ((sel ? ack_b : ack_a) === 1'b1) got = 1'b1;
         else k++;
      end
      chk({tag, "/lat"},   k, lat);
      chk({tag, "/err"},   {31'd0, sel ? err_b : err_a}, {31'd0, e_err});
      chk({tag, "/rdata"}, {24'd0, sel ? rdata_b : rdata_a}, {24'd0, e_rd});
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      @(posedge clk); #1;
      chk({tag, "/pulse"}, {31'd0, sel ? ack_b : ack_a}, 32'd0);
   endtask

   initial begin
      int   k;
      logic got;

      // 1: reset held three cycles, req raised in the last one.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) req_a = 1'b1;
         @(posedge clk); #1;
         outs_zero($sformatf("rst%0d", i));
      end
      @(negedge clk);
      req_a = 1'b0;
      rst_n = 1'b1;
      xact(0, 1'b0, 8'h40, 8'h00, 3, 1'b0, 8'h00, "rd40_after_rst");

      // 2: write then read back inside the window.
      xact(0, 1'b1, 8'h45, 8'hA5, 3, 1'b0, 8'h00, "wr45");
      xact(0, 1'b0, 8'h45, 8'h00, 3, 1'b0, 8'hA5, "rd45");

      // 3: window edges; an out-of-range write must not alias onto word 0.
      xact(0, 1'b0, 8'h3F, 8'h00, 1, 1'b1, 8'h00, "rd3F");
      xact(0, 1'b1, 8'h4F, 8'h5A, 3, 1'b0, 8'h00, "wr4F");
      xact(0, 1'b0, 8'h4F, 8'h00, 3, 1'b0, 8'h5A, "rd4F");
      xact(0, 1'b0, 8'h50, 8'h00, 1, 1'b1, 8'h00, "rd50");
      xact(0, 1'b1, 8'h50, 8'h11, 1, 1'b1, 8'h00, "wr50");
      xact(0, 1'b0, 8'h40, 8'h00, 3, 1'b0, 8'h00, "rd40_unchanged");
      xact(0, 1'b0, 8'h4F, 8'h00, 3, 1'b0, 8'h5A, "rd4F_unchanged");

      // 4: window touching 2^ADDR_W, zero wait states.
      xact(1, 1'b1, 8'hFF, 8'h3C, 1, 1'b0, 8'h00, "b_wrFF");
      xact(1, 1'b0, 8'hFF, 8'h00, 1, 1'b0, 8'h3C, "b_rdFF");
      xact(1, 1'b0, 8'h00, 8'h00, 1, 1'b1, 8'h00, "b_rd00");
      xact(1, 1'b0, 8'hF7, 8'h00, 1, 1'b1, 8'h00, "b_rdF7");

      // 5a: reset asserted during the ack cycle clears the outputs without a clock edge.
      xact(0, 1'b1, 8'h41, 8'h77, 3, 1'b0, 8'h00, "wr41");
      @(negedge clk);
      wr = 1'b0; addr = 8'h41; req_a = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 12) begin
         @(posedge clk); #1;
         if (ack_a === 1'b1) got = 1'b1; else k++;
      end
      chk("ack_rd41/lat", k, 3);
      chk("ack_rd41/rdata", {24'd0, rdata_a}, 32'h77);
      #1 rst_n = 1'b0; req_a = 1'b0;
      #1 outs_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 5b: reset pulsed during the wait phase; no ack afterwards and storage cleared.
      xact(0, 1'b1, 8'h41, 8'h77, 3, 1'b0, 8'h00, "wr41_again");
      @(negedge clk);
      wr = 1'b0; addr = 8'h41; req_a = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0; req_a = 1'b0;
      #1 outs_zero("wait_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("wait_rst_noack%0d", i), {31'd0, ack_a}, 32'd0);
      end
      xact(0, 1'b0, 8'h41, 8'h00, 3, 1'b0, 8'h00, "rd41_cleared");

      // 6: req held across ack is not re-accepted until it drops.
      @(negedge clk);
      wr = 1'b1; addr = 8'h42; wdata = 8'h33; req_a = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 12) begin
         @(posedge clk); #1;
         if (ack_a === 1'b1) got = 1'b1; else k++;
      end
      chk("hold/lat", k, 3);
      @(negedge clk);
      wr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_noack%0d", i), {31'd0, ack_a}, 32'd0);
      end
      @(negedge clk);
      req_a = 1'b0;
      xact(0, 1'b0, 8'h42, 8'h00, 3, 1'b0, 8'h33, "rd42");

      // 6b: req dropped one cycle into the wait phase.
      @(negedge clk);
      wr = 1'b1; addr = 8'h43; wdata = 8'h99; req_a = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      req_a = 1'b0;
      k = 0; got = 1'b0;
      while (!got && k < 6) begin
         @(posedge clk); #1;
         if (ack_a === 1'b1) got = 1'b1; else k++;
      end
`ifdef SLAVE_ABORT_EN
      chk("abort/noack", {31'd0, got}, 32'd0);
      xact(0, 1'b0, 8'h43, 8'h00, 3, 1'b0, 8'h00, "rd43_aborted");
`else
      chk("drop/ack", {31'd0, got}, 32'd1);
      chk("drop/lat", k + 1, 3);
      chk("drop/err", {31'd0, err_a}, 32'd0);
      @(posedge clk); #1;
      chk("drop/pulse", {31'd0, ack_a}, 32'd0);
      xact(0, 1'b0, 8'h43, 8'h00, 3, 1'b0, 8'h99, "rd43_completed");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
